alu_exec_stage: RTL and testbench

Registered execute stage of the 32-bit datapath, sitting between decode and the existing combinational `ALU`. It accepts one decoded operation per cycle through a valid/ready handshake and selects operand B from the register or the immediate. It resolves read-after-write hazards by forwarding from its own output register and from the writeback bus, drives the `ALU`, and holds the result in an output register for the memory/writeback stage.

---
 rtl/alu_pkg.sv | 18 +
 rtl/ALU.sv | 29 ++
 rtl/alu_exec_stage.sv | 133 +++++++++++++
 tb/tb_alu_exec_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage and the combinational ALU.
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4,
        SLL = 3'd5,
        SRL = 3'd6,
        SRA = 3'd7
    } alu_mode_t;

endpackage

// File: rtl/ALU.sv
// Combinational 32-bit ALU: arithmetic modulo 2^XLEN, no flags.
module ALU
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      mode,
    output logic [XLEN-1:0] X
);

    logic [4:0] shamt;

    always_comb begin
        shamt = B[4:0];
        X     = '0;
        case (alu_mode_t'(mode))
            ADD:     X = A + B;
            SUB:     X = A - B;
            AND:     X = A & B;
            OR:      X = A | B;
            XOR:     X = A ^ B;
            SLL:     X = A << shamt;
            SRL:     X = A >> shamt;
            SRA:     X = $unsigned($signed(A) >>> shamt);
            default: X = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage: operand forwarding, ALU drive, and a single
// valid/ready output register for the memory/writeback stage.
module alu_exec_stage #(
    parameter int          XLEN         = alu_pkg::XLEN,
    parameter int          RADDR_W      = alu_pkg::RADDR_W,
    parameter logic [31:0] OP_COUNT_RST = 32'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_mode,
    input  logic [RADDR_W-1:0] in_rs1,
    input  logic [RADDR_W-1:0] in_rs2,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [XLEN-1:0]    in_imm,
    input  logic               in_use_imm,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_rd_we,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_result,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_rd_we,
    output logic [31:0]        op_count
);
    import alu_pkg::*;

    logic               out_valid_q,  out_valid_d;
    logic [XLEN-1:0]    out_result_q, out_result_d;
    logic [RADDR_W-1:0] out_rd_q,     out_rd_d;
    logic               out_rd_we_q,  out_rd_we_d;
    logic [31:0]        op_count_q,   op_count_d;

    logic            accept;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_x;

    // Own output register beats the writeback bus: it holds the younger value.
    function automatic logic [XLEN-1:0] fwd_src(
        input logic [RADDR_W-1:0] rs,
        input logic [XLEN-1:0]    rf_data
    );
        if (rs == '0)
            return '0;
        if (out_valid_q && out_rd_we_q && (out_rd_q == rs))
            return out_result_q;
        if (wb_we && (wb_rd == rs))
            return wb_data;
        return rf_data;
    endfunction

    function automatic logic [XLEN-1:0] fwd_operand_a(
        input logic [RADDR_W-1:0] rs,
        input logic [XLEN-1:0]    rf_data
    );
        return fwd_src(rs, rf_data);
    endfunction

    function automatic logic [XLEN-1:0] fwd_operand_b(
        input logic [RADDR_W-1:0] rs,
        input logic [XLEN-1:0]    rf_data,
        input logic [XLEN-1:0]    imm,
        input logic               use_imm
    );
        return use_imm ? imm : fwd_src(rs, rf_data);
    endfunction

    always_comb begin
        op_a = fwd_operand_a(in_rs1, in_rs1_data);
        op_b = fwd_operand_b(in_rs2, in_rs2_data, in_imm, in_use_imm);
    end

    ALU u_alu (
        .A    (op_a),
        .B    (op_b),
        .mode (in_mode),
        .X    (alu_x)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        out_rd_we_d  = out_rd_we_q;
        op_count_d   = op_count_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            // Also covers a same-edge transfer: the new op simply replaces the old.
            out_valid_d  = 1'b1;
            out_result_d = alu_x;
            out_rd_d     = in_rd;
            out_rd_we_d  = in_rd_we;
            op_count_d   = op_count_q + 32'd1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            out_rd_we_q  <= 1'b0;
            op_count_q   <= OP_COUNT_RST;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            out_rd_we_q  <= out_rd_we_d;
            op_count_q   <= op_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;
    assign out_rd_we  = out_rd_we_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with hand-computed expected values.
module tb_alu_exec_stage;

    localparam logic [2:0] M_ADD = 3'd0, M_SUB = 3'd1, M_AND = 3'd2, M_OR = 3'd3,
                           M_XOR = 3'd4, M_SLL = 3'd5, M_SRL = 3'd6, M_SRA = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n, rst_n_w;
    logic        in_valid, in_use_imm, in_rd_we, wb_we, flush, out_ready;
    logic [2:0]  in_mode;
    logic [4:0]  in_rs1, in_rs2, in_rd, wb_rd;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, wb_data;

    logic        in_ready, out_valid, out_rd_we;
    logic [31:0] out_result, op_count;
    logic [4:0]  out_rd;

    logic        w_in_ready, w_out_valid, w_out_rd_we;
    logic [31:0] w_out_result, w_op_count;
    logic [4:0]  w_out_rd;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_cnt;

    logic [2:0]  tm [7];
    logic [31:0] ta [7];
    logic [31:0] tbv[7];
    logic [31:0] te [7];

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .op_count(op_count)
    );

    // Second instance with the counter starting just below wrap.
    alu_exec_stage #(.OP_COUNT_RST(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n_w), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_mode(in_mode), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_result(w_out_result),
        .out_rd(w_out_rd), .out_rd_we(w_out_rd_we), .op_count(w_op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] m, input logic [4:0] r1, input logic [31:0] d1,
                      input logic [4:0] r2, input logic [31:0] d2, input logic [31:0] imm,
                      input logic ui, input logic [4:0] rd, input logic we);
        in_valid    = 1'b1;
        in_mode     = m;
        in_rs1      = r1;
        in_rs1_data = d1;
        in_rs2      = r2;
        in_rs2_data = d2;
        in_imm      = imm;
        in_use_imm  = ui;
        in_rd       = rd;
        in_rd_we    = we;
    endtask

    initial begin
        tm  = '{M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA, M_SRA};
        ta  = '{32'hCC, 32'hCC, 32'hCC, 32'hCC, 32'hCC, 32'hCC, 32'h8000_0000};
        tbv = '{32'hCA, 32'hCA, 32'hCA, 32'h2, 32'h2, 32'h2, 32'h4};
        te  = '{32'hC8, 32'hCE, 32'h06, 32'h330, 32'h33, 32'h33, 32'hF800_0000};

        rst_n = 1'b0; rst_n_w = 1'b0;
        in_valid = 0; in_mode = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_data = 0;
        in_rs2_data = 0; in_imm = 0; in_use_imm = 0; in_rd = 0; in_rd_we = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0; flush = 0; out_ready = 1;
        exp_cnt = 0;

        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_out_rd_we", {31'd0, out_rd_we}, 32'd0);
        chk("rst_op_count", op_count, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD from register file
        op(M_ADD, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 1'b0, 5'd5, 1'b1);
        tick(); exp_cnt++;
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_result", out_result, 32'h3);
        chk("add_rd", {27'd0, out_rd}, 32'd5);
        chk("add_rd_we", {31'd0, out_rd_we}, 32'd1);
        chk("add_count", op_count, 32'd1);

        // SUB via immediate
        op(M_SUB, 5'd1, 32'h20, 5'd2, 32'h999, 32'hA, 1'b1, 5'd5, 1'b0);
        tick(); exp_cnt++;
        chk("sub_imm", out_result, 32'h16);

        for (int i = 0; i < 7; i++) begin
            op(tm[i], 5'd1, ta[i], 5'd2, tbv[i], 32'h0, 1'b0, 5'd10, 1'b0);
            tick(); exp_cnt++;
            chk($sformatf("mode%0d_case%0d", tm[i], i), out_result, te[i]);
        end
        chk("count_after_modes", op_count, exp_cnt);

        // Forwarding from output register
        op(M_ADD, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 1'b0, 5'd3, 1'b1);
        tick(); exp_cnt++;
        chk("fwd_op1", out_result, 32'h3);
        op(M_ADD, 5'd3, 32'h99, 5'd0, 32'h77, 32'h0, 1'b0, 5'd6, 1'b1);
        tick(); exp_cnt++;
        chk("fwd_outreg_rs0", out_result, 32'h3);

        // Forwarding from writeback bus
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h50;
        op(M_ADD, 5'd0, 32'h11, 5'd4, 32'h12, 32'h0, 1'b0, 5'd7, 1'b1);
        tick(); exp_cnt++;
        chk("fwd_wb", out_result, 32'h50);

        // Both sources match: output register wins
        wb_rd = 5'd7; wb_data = 32'h1000;
        op(M_ADD, 5'd7, 32'h1, 5'd0, 32'h0, 32'h0, 1'b0, 5'd8, 1'b1);
        tick(); exp_cnt++;
        chk("fwd_priority", out_result, 32'h50);

        // rs=0 with wb_rd=0 stays zero
        wb_rd = 5'd0; wb_data = 32'h55;
        op(M_OR, 5'd0, 32'h33, 5'd0, 32'h44, 32'h0, 1'b0, 5'd9, 1'b1);
        tick(); exp_cnt++;
        chk("fwd_rs0_wb0", out_result, 32'h0);
        wb_we = 1'b0;

        // Output register with rd_we=0 must not forward
        op(M_ADD, 5'd9, 32'h7, 5'd0, 32'h0, 32'h0, 1'b0, 5'd11, 1'b0);
        tick(); exp_cnt++;
        chk("fwd_outreg_rd9", out_result, 32'h0);
        op(M_ADD, 5'd11, 32'h7, 5'd0, 32'h0, 32'h0, 1'b0, 5'd12, 1'b0);
        tick(); exp_cnt++;
        chk("no_fwd_when_we0", out_result, 32'h7);

        // Backpressure
        out_ready = 1'b0;
        op(M_ADD, 5'd1, 32'h100, 5'd2, 32'h200, 32'h0, 1'b0, 5'd12, 1'b0);
        #1;
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stall_hold_%0d", i), out_result, 32'h7);
            chk($sformatf("stall_rdy_%0d", i), {31'd0, in_ready}, 32'd0);
            chk($sformatf("stall_cnt_%0d", i), op_count, exp_cnt);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        tick(); exp_cnt++;
        chk("release_result", out_result, 32'h300);
        chk("release_valid", {31'd0, out_valid}, 32'd1);
        chk("release_count", op_count, exp_cnt);

        // Flush alongside an incoming op
        flush = 1'b1;
        op(M_ADD, 5'd1, 32'h5, 5'd2, 32'h6, 32'h0, 1'b0, 5'd13, 1'b1);
        tick();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_count", op_count, exp_cnt);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush_idle_valid", {31'd0, out_valid}, 32'd0);

        // Transfer without accept clears valid, datapath holds
        op(M_XOR, 5'd1, 32'hF0, 5'd2, 32'hFF, 32'h0, 1'b0, 5'd14, 1'b1);
        tick(); exp_cnt++;
        chk("xor_result", out_result, 32'h0F);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_result_held", out_result, 32'h0F);
        chk("drain_count", op_count, exp_cnt);

        // Counter wrap on the preloaded instance
        rst_n_w = 1'b1;
        #1;
        chk("wrap_preload", w_op_count, 32'hFFFF_FFFF);
        op(M_ADD, 5'd1, 32'hAA, 5'd2, 32'h1, 32'h0, 1'b0, 5'd15, 1'b1);
        tick(); exp_cnt++;
        chk("wrap_to_zero", w_op_count, 32'h0);
        chk("wrap_result", w_out_result, 32'hAB);
        chk("main_result", out_result, 32'hAB);

        // Async reset mid-stall
        out_ready = 1'b0;
        op(M_SUB, 5'd1, 32'h10, 5'd2, 32'h1, 32'h0, 1'b0, 5'd16, 1'b1);
        tick();
        chk("prereset_valid", {31'd0, out_valid}, 32'd1);
        chk("prereset_hold", out_result, 32'hAB);
        chk("prereset_count", op_count, exp_cnt);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_result", out_result, 32'd0);
        chk("arst_rd", {27'd0, out_rd}, 32'd0);
        chk("arst_rd_we", {31'd0, out_rd_we}, 32'd0);
        chk("arst_count", op_count, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
